// File: rtl/bcd_counter_ndigit.sv
// Multi-digit BCD up/down counter with load, cascade tc and wrap flag.
// Chain instances by feeding tc into the next instance's en.
module bcd_counter_ndigit #(
   parameter int DIGITS      = 2,
   parameter bit STICKY_WRAP = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  wrap_clr,
   output logic [4*DIGITS-1:0]   cnt,
   output logic                  tc,
   output logic                  wrap,
   output logic                  ld_err
);

   logic [4*DIGITS-1:0] cnt_q, cnt_d;
   logic                wrap_q, wrap_d;
   logic                lderr_q, lderr_d;

   logic [4*DIGITS-1:0] step;
   logic [4*DIGITS-1:0] clamped;
   logic                all9, all0;
   logic                carry;
   logic                bad;
   logic [3:0]          dig;

   always_comb begin
      all9    = 1'b1;
      all0    = 1'b1;
      carry   = 1'b1;
      bad     = 1'b0;
      dig     = '0;
      step    = cnt_q;
      clamped = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         dig = cnt_q[4*i +: 4];
         if (dig != 4'd9) all9 = 1'b0;
         if (dig != 4'd0) all0 = 1'b0;
         // carry/borrow ripples only through saturated digits
         if (carry) begin
            if (up_dn) begin
               if (dig == 4'd9) begin
                  step[4*i +: 4] = 4'd0;
               end else begin
                  step[4*i +: 4] = dig + 4'd1;
                  carry          = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  step[4*i +: 4] = 4'd9;
               end else begin
                  step[4*i +: 4] = dig - 4'd1;
                  carry          = 1'b0;
               end
            end
         end
         if (load_val[4*i +: 4] > 4'd9) begin
            clamped[4*i +: 4] = 4'd9;
            bad               = 1'b1;
         end
      end
   end

   assign tc = en & ~load & (up_dn ? all9 : all0);

   always_comb begin
      cnt_d   = cnt_q;
      lderr_d = load & bad;
      if (load) begin
         cnt_d = clamped;
      end else if (en) begin
         cnt_d = step;
      end
      if (STICKY_WRAP) begin
         // a new wrap beats a coincident clear
         if (tc) begin
            wrap_d = 1'b1;
         end else if (wrap_clr) begin
            wrap_d = 1'b0;
         end else begin
            wrap_d = wrap_q;
         end
      end else begin
         wrap_d = tc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         lderr_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         lderr_q <= lderr_d;
      end
   end

   assign cnt    = cnt_q;
   assign wrap   = wrap_q;
   assign ld_err = lderr_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit, DIGITS=2, sticky and pulse wrap.
module tb_bcd_counter_ndigit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic       wrap_clr = 1'b0;

   logic [7:0] cnt, cnt_n;
   logic       tc, tc_n;
   logic       wrap, wrap_n;
   logic       ld_err, ld_err_n;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] cnt;
      logic       tc;
      logic       w;
      logic       wns;
      logic       le;
      string      nm;
   } exp_t;

   exp_t q[$];

   bcd_counter_ndigit #(.DIGITS(2), .STICKY_WRAP(1'b1)) u_dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
      .load(load), .load_val(load_val), .wrap_clr(wrap_clr),
      .cnt(cnt), .tc(tc), .wrap(wrap), .ld_err(ld_err)
   );

   bcd_counter_ndigit #(.DIGITS(2), .STICKY_WRAP(1'b0)) u_ns (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
      .load(load), .load_val(load_val), .wrap_clr(wrap_clr),
      .cnt(cnt_n), .tc(tc_n), .wrap(wrap_n), .ld_err(ld_err_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: one expected entry per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.nm, ".cnt"},   cnt, e.cnt);
         chk({e.nm, ".tc"},    {7'd0, tc}, {7'd0, e.tc});
         chk({e.nm, ".wrap"},  {7'd0, wrap}, {7'd0, e.w});
         chk({e.nm, ".wrapp"}, {7'd0, wrap_n}, {7'd0, e.wns});
         chk({e.nm, ".lderr"}, {7'd0, ld_err}, {7'd0, e.le});
         chk({e.nm, ".cntp"},  cnt_n, e.cnt);
      end
   end

   // drive inputs just after an edge; expect state after that edge
   task automatic cyc(input logic r, input logic e, input logic u,
                      input logic l, input logic [7:0] lv,
                      input logic wc, input logic [7:0] ecnt,
                      input logic ew, input logic ewns,
                      input logic ele, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst      = r;
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = lv;
      wrap_clr = wc;
      x.cnt = ecnt;
      x.tc  = e & ~l & (u ? (ecnt == 8'h99) : (ecnt == 8'h00));
      x.w   = ew;
      x.wns = ewns;
      x.le  = ele;
      x.nm  = nm;
      q.push_back(x);
   endtask

   initial begin
      //  r  e  u  l  lv     wc cnt    w  wp le
      cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rst_a");
      cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rst_b");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rst_rel");
      cyc(1, 0, 1, 1, 8'h07, 0, 8'h00, 0, 0, 0, "idle");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h07, 0, 0, 0, "ld07");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h08, 0, 0, 0, "up08");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h09, 0, 0, 0, "up09");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h10, 0, 0, 0, "up10");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h11, 0, 0, 0, "up11");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h12, 0, 0, 0, "up12");
      cyc(1, 0, 1, 1, 8'h98, 0, 8'h12, 0, 0, 0, "hold12");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h98, 0, 0, 0, "ld98");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h99, 0, 0, 0, "tc99");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0, "wrap_up");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, "wrap_stk");
      cyc(1, 0, 1, 0, 8'h00, 1, 8'h00, 1, 0, 0, "wrap_hold");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "wrap_clr");
      cyc(1, 0, 0, 1, 8'h01, 0, 8'h00, 0, 0, 0, "pre_ld01");
      cyc(1, 1, 0, 0, 8'h00, 0, 8'h01, 0, 0, 0, "ld01");
      cyc(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "tc00");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h99, 1, 1, 0, "wrap_dn");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h99, 1, 0, 0, "wrap_pls");
      cyc(1, 1, 1, 0, 8'h00, 1, 8'h99, 1, 0, 0, "clr_at_tc");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0, "set_wins");
      cyc(1, 0, 1, 0, 8'h00, 1, 8'h00, 1, 0, 0, "clr2");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "clr2_done");
      cyc(1, 0, 1, 1, 8'h45, 0, 8'h00, 0, 0, 0, "pre_ld45");
      cyc(1, 1, 1, 1, 8'h3C, 0, 8'h45, 0, 0, 0, "ld45");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h39, 0, 0, 1, "ld_clamp");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h40, 0, 0, 0, "after_clamp");
      cyc(1, 0, 1, 1, 8'hA5, 0, 8'h40, 0, 0, 0, "pre_ldA5");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h95, 0, 0, 1, "clamp_hi");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h95, 0, 0, 0, "lderr_pls");
      cyc(1, 0, 1, 1, 8'h10, 0, 8'h95, 0, 0, 0, "pre_ld10");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0, 0, "hold_a");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h10, 0, 0, 0, "hold_b");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0, 0, "hold_c");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h10, 0, 0, 0, "hold_d");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h10, 0, 0, 0, "hold_e");
      cyc(1, 1, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0, "dir_up");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h10, 0, 0, 0, "dir_dn");
      cyc(1, 1, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0, "dir_up2");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h10, 0, 0, 0, "dir_dn2");
      cyc(1, 1, 0, 0, 8'h00, 0, 8'h10, 0, 0, 0, "hold_f");
      cyc(1, 0, 0, 0, 8'h00, 0, 8'h09, 0, 0, 0, "borrow09");
      cyc(1, 0, 1, 1, 8'h37, 0, 8'h09, 0, 0, 0, "pre_ld37");
      cyc(1, 1, 1, 0, 8'h00, 0, 8'h37, 0, 0, 0, "ld37");
      cyc(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "async_rst");
      cyc(0, 0, 1, 1, 8'hFF, 0, 8'h00, 0, 0, 0, "rst_ld");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "rst_ld_b");
      cyc(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, "ld_dropped");
      @(negedge clk);
      #1;
      chk("drain", 8'(q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_counter_ndigit.md
Name: bcd_counter_ndigit

Overview:
Parametrised multi-digit BCD counter. It generalises the team's single-digit 0-to-9 counter to DIGITS cascaded decades and adds up/down counting, parallel load, a cascade terminal-count output and a sticky wrap flag. It is used as the display/event counter core in timer and scoreboard designs, and can be chained via tc into a further instance's en.

Parameters:
DIGITS, 2, number of BCD decades (1..8); count range 0 .. 10^DIGITS-1
STICKY_WRAP, 1, 1 = wrap flag holds until wrap_clr; 0 = wrap is a one-cycle pulse

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  count enable; one step per clock while high
up_dn  input  1  1 = count up, 0 = count down; sampled every enabled cycle
load  input  1  synchronous parallel load strobe
load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0]
wrap_clr  input  1  clears the wrap flag (STICKY_WRAP=1 only)
cnt  output  4*DIGITS  current BCD count, digit 0 in bits [3:0]
tc  output  1  terminal count / cascade carry (combinational)
wrap  output  1  wrap-around indicator (registered)
ld_err  output  1  one-cycle pulse: load contained a non-BCD digit

Behaviour:
- Reset (rst=0, async): cnt=0, wrap=0, ld_err=0 immediately, independent of clk. Release is synchronous to the next rising edge; the first count happens on the first edge with en=1 after release.
- Priority per edge: load > en > hold.
- load=1: cnt <= load_val on the same edge (1-cycle latency), regardless of en.
  - Any digit >9 is clamped to 9; ld_err=1 on the following cycle only.
  - Load never sets or clears wrap.
- en=1, load=0, up_dn=1: digit 0 +1.
  - Digit i (i>0) +1 iff all lower digits ==9; each 9 rolls to 0.
- en=1, load=0, up_dn=0: digit 0 -1.
  - Digit i (i>0) -1 iff all lower digits ==0; each 0 rolls to 9.
- Full wrap: up at all-9s -> all-0s; down at all-0s -> all-9s. On that edge wrap becomes 1.
  - STICKY_WRAP=1: wrap holds until a wrap_clr edge. If wrap_clr coincides with a new wrap, set wins.
  - STICKY_WRAP=0: wrap is high for exactly one cycle; wrap_clr is ignored.
- en=0, load=0: cnt holds, including when up_dn changes.
- tc = en & ~load & (up_dn ? cnt==all-9s : cnt==all-0s). It is combinational, so it is high in the cycle before the wrapping edge. It feeds en of the next cascaded instance.
- Direction change mid-count takes effect on the same edge with no extra step, e.g. 10 up then down -> 09.
- Reset asserted mid-count or mid-load: all state clears immediately; a pending load is discarded.
- cnt never holds a non-BCD digit value.

Test Plan:
- Reset: DIGITS=2, rst=0 for 2 cycles then 1, en=0 -> cnt=00, wrap=0, ld_err=0. Asserting rst=0 mid-count at cnt=37 -> cnt=00 without waiting for a clock edge.
- Up count with carry: load 07, then en=1, up_dn=1 for 5 cycles -> 08, 09, 10, 11, 12. Digit 1 increments exactly on the 09->10 edge.
- Wrap and tc up: load 98, en=1, up_dn=1 -> 99 with tc=1 in that cycle. Next edge -> 00 and wrap=1. Wrap stays 1 (STICKY_WRAP=1) until a wrap_clr pulse, then 0.
- Down count and wrap: load 01, en=1, up_dn=0 -> 00 with tc=1, then 99 with wrap=1. With STICKY_WRAP=0, wrap is high for exactly one cycle.
- Load priority and error: at cnt=45 with en=1, drive load=1, load_val=0x3C -> cnt=39, ld_err high for one cycle. The next enabled up edge gives 40.
- Hold and direction change: en=0 for 4 cycles while toggling up_dn -> cnt unchanged. Then en=1 with up_dn toggled each cycle from 10 -> 11, 10, 11 (no double steps).
